// File: rtl/core_alu_arb.sv
// Two-requester round-robin front end for a shared, externally registered ALU.
// state | meaning: S_IDLE wait and grant | S_EXEC ALU working | S_RESP result held for consumer
module core_alu_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [5:0]       req_op_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [15:0]      rsp_data_o,
    output logic [2:0]       alu_op_o,
    output logic [15:0]      alu_a_o,
    output logic [15:0]      alu_b_o,
    input  logic [15:0]      alu_c_i,
    output logic [CNT_W-1:0] done_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_q;
    logic              id_q;
    logic [15:0]       data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              gnt_id;
    logic              gnt_en;

    // Contest goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        gnt_id = req_valid_i[1];
        if (&req_valid_i) begin
            gnt_id = ~last_q;
        end
    end

    // Reset gates the grant so ready and ALU outputs drop the moment rst_i falls.
    assign gnt_en = rst_i && (state_q == S_IDLE) && (|req_valid_i);

    always_comb begin
        state_d     = state_q;
        req_ready_o = 2'b00;
        alu_op_o    = 3'd0;
        alu_a_o     = 16'd0;
        alu_b_o     = 16'd0;
        case (state_q)
            S_IDLE: begin
                if (gnt_en) begin
                    req_ready_o = gnt_id ? 2'b10 : 2'b01;
                    alu_op_o    = gnt_id ? req_op_i[5:3]  : req_op_i[2:0];
                    alu_a_o     = gnt_id ? req_a_i[31:16] : req_a_i[15:0];
                    alu_b_o     = gnt_id ? req_b_i[31:16] : req_b_i[15:0];
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            data_q  <= 16'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_en) begin
                last_q <= gnt_id;
                id_q   <= gnt_id;
            end
            if (state_q == S_EXEC) begin
                data_q <= alu_c_i;
            end
            if ((state_q == S_RESP) && rsp_ready_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = data_q;
    assign done_cnt_o  = cnt_q;

endmodule

// File: tb/tb_core_alu_arb.sv
// Bench for core_alu_arb: directed and random transactions against a
// transaction-level model of arbitration, ALU results and completion count.
module tb_core_alu_arb;

    localparam int CW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [5:0]    req_op = '0;
    logic [31:0]   req_a = '0;
    logic [31:0]   req_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_id;
    logic [15:0]   rsp_data;
    logic [2:0]    alu_op;
    logic [15:0]   alu_a;
    logic [15:0]   alu_b;
    logic [15:0]   alu_c = '0;
    logic [CW-1:0] done_cnt;

    int checks = 0;
    int errors = 0;
    int last_w = 1;
    int ecnt   = 0;

    core_alu_arb #(.CNT_W(CW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .alu_op_o    (alu_op),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_c_i     (alu_c),
        .done_cnt_o  (done_cnt)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a ^ b;
            3'd4:    return a | b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return b;
        endcase
    endfunction

    // Shared ALU: one register stage between operands and result.
    always @(posedge clk_i) alu_c <= alu_fn(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int n, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        req_valid[n]       = 1'b1;
        req_op[3*n +: 3]   = op;
        req_a[16*n +: 16]  = a;
        req_b[16*n +: 16]  = b;
    endtask

    task automatic set_rand(input int n);
        set_req(n, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    endtask

    // One full transaction from the current IDLE cycle; bp = RESP cycles with rsp_ready low.
    task automatic do_op(input int bp);
        int          w;
        logic [2:0]  eo;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] ed;
        rsp_ready = (bp == 0);
        #1;
        if (req_valid == 2'b11) w = 1 - last_w;
        else                    w = req_valid[1] ? 1 : 0;
        last_w = w;
        eo = req_op[3*w +: 3];
        ea = req_a[16*w +: 16];
        eb = req_b[16*w +: 16];
        ed = alu_fn(eo, ea, eb);
        chk("grant_ready", 32'(req_ready), (w == 1) ? 32'd2 : 32'd1);
        chk("grant_alu_op", 32'(alu_op), 32'(eo));
        chk("grant_alu_a", 32'(alu_a), 32'(ea));
        chk("grant_alu_b", 32'(alu_b), 32'(eb));
        chk("grant_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        req_valid[w] = 1'b0;
        #1;
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_alu_zero", 32'(|{alu_op, alu_a, alu_b}), 32'd0);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_data", 32'(rsp_data), 32'(ed));
        chk("resp_id", 32'(rsp_id), 32'(w));
        chk("resp_ready", 32'(req_ready), 32'd0);
        chk("resp_cnt", 32'(done_cnt), 32'(ecnt % (1 << CW)));
        for (int i = 1; i < bp; i++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(ed));
            chk("hold_id", 32'(rsp_id), 32'(w));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_cnt", 32'(done_cnt), 32'(ecnt % (1 << CW)));
        end
        rsp_ready = 1'b1;
        tick();
        ecnt++;
        chk("done_cnt", 32'(done_cnt), 32'(ecnt % (1 << CW)));
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_alu"}, 32'(|{alu_op, alu_a, alu_b}), 32'd0);
        chk({tag, "_cnt"}, 32'(done_cnt), 32'd0);
        chk({tag, "_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_id"}, 32'(rsp_id), 32'd0);
    endtask

    initial begin
        // Reset state, with both requesters pushing to show ready is held off.
        set_req(0, 3'd2, 16'hAAAA, 16'h5555);
        set_req(1, 3'd4, 16'h1234, 16'h4321);
        #3;
        chk_reset_outputs("reset");
        req_valid = 2'b00;
        tick();
        tick();
        rst_i = 1'b1;

        // Single operation from requester 0.
        set_req(0, 3'd0, 16'h0003, 16'h0004);
        do_op(0);

        // Continuous contention; grants alternate.
        set_req(0, 3'd1, 16'h0010, 16'h0001);
        set_req(1, 3'd1, 16'h0010, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b11;
            do_op(0);
        end

        // Backpressure on requester 1 (0xFF00 ^ 0x0F0F).
        set_req(1, 3'd3, 16'hFF00, 16'h0F0F);
        do_op(5);

        // Reset during EXEC discards the op and restores the pointer.
        set_req(0, 3'd0, 16'h1234, 16'h0001);
        #1;
        chk("rst_grant_ready", 32'(req_ready), 32'd1);
        last_w = 0;
        tick();
        req_valid = 2'b00;
        set_req(0, 3'd1, 16'h0100, 16'h0001);
        set_req(1, 3'd1, 16'h0200, 16'h0001);
        #1;
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("midop");
        ecnt   = 0;
        last_w = 1;
        req_valid = 2'b00;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        chk("no_rsp_after_rst_a", 32'(rsp_valid), 32'd0);
        tick();
        chk("no_rsp_after_rst_b", 32'(rsp_valid), 32'd0);
        req_valid = 2'b11;
        do_op(0);

        // Four more completions make five since reset: 2-bit counter wraps to 1.
        for (int k = 0; k < 4; k++) begin
            if (!req_valid[0]) set_rand(0);
            if (!req_valid[1]) set_rand(1);
            do_op(0);
        end
        chk("cnt_wrap", 32'(done_cnt), 32'd1);

        // Random traffic with random backpressure.
        for (int k = 0; k < 24; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!req_valid[n] && ($urandom_range(0, 1) == 1)) set_rand(n);
            end
            if (req_valid == 2'b00) set_rand(int'($urandom_range(0, 1)));
            do_op(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
